// File: rtl/mem_ctrl_m.sv
// mem_ctrl_m -- MEM-stage controller for the five-stage MIPS pipeline.
//
// Decodes the M-stage instruction into write-back controls and runs a
// request/acknowledge transaction with a variable-latency data memory.
// Supports word, half-word and byte accesses with byte enables and
// load extension. The pipeline is stalled while a transaction is
// outstanding. Misaligned accesses and memory timeouts are flagged.
//
// Parameters:
//   ADDR_W   data-memory address width
//   SUBWORD  1: decode lb/lbu/lh/lhu/sb/sh; 0: treat them as non-memory
//   TIMEOUT  BUSY cycles without mem_ack before a bus error (1..255)
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   instr_M, valid_M   M-stage instruction and its valid flag
//   addr_M, wdata_M    effective address, store data
//   mem_req/we/addr/be/wdata   registered memory request
//   mem_ack, mem_rdata         memory completion and read data
//   stall_M            freeze the upstream pipeline registers
//   RegWrite, Mem2Reg  write-back controls (Mem2Reg: 00 ALU, 01 load, 10 PC+8)
//   load_data          registered, extended load result
//   exc_adel/exc_ades  misaligned load/store (combinational)
//   bus_err            one-cycle timeout pulse (registered)
module mem_ctrl_m #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned SUBWORD = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_M,
  input  logic              valid_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [31:0]       wdata_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall_M,
  output logic              RegWrite,
  output logic [1:0]        Mem2Reg,
  output logic [31:0]       load_data,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              bus_err
);

  localparam bit         SW_EN  = (SUBWORD != 0);
  localparam logic [7:0] TMO_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  // ---------------- decode ----------------
  logic [5:0] w_op, w_fn;
  logic w_addu, w_subu, w_ori, w_lui, w_jal;
  logic w_lw, w_sw, w_lb, w_lbu, w_lh, w_lhu, w_sb, w_sh;
  logic w_load, w_store, w_word, w_half, w_byte;
  logic w_mis, w_memop_ok;
  logic w_unused;

  assign w_op   = instr_M[31:26];
  assign w_fn   = instr_M[5:0];
  // register and immediate fields play no part in this decode
  assign w_unused = ^instr_M[25:6];

  assign w_addu = (w_op == 6'b000000) && (w_fn == 6'b100001);
  assign w_subu = (w_op == 6'b000000) && (w_fn == 6'b100011);
  assign w_ori  = (w_op == 6'b001101);
  assign w_lui  = (w_op == 6'b001111);
  assign w_jal  = (w_op == 6'b000011);
  assign w_lw   = (w_op == 6'b100011);
  assign w_sw   = (w_op == 6'b101011);
  assign w_lb   = SW_EN && (w_op == 6'b100000);
  assign w_lbu  = SW_EN && (w_op == 6'b100100);
  assign w_lh   = SW_EN && (w_op == 6'b100001);
  assign w_lhu  = SW_EN && (w_op == 6'b100101);
  assign w_sb   = SW_EN && (w_op == 6'b101000);
  assign w_sh   = SW_EN && (w_op == 6'b101001);

  assign w_load  = w_lw | w_lb | w_lbu | w_lh | w_lhu;
  assign w_store = w_sw | w_sb | w_sh;
  assign w_word  = w_lw | w_sw;
  assign w_half  = w_lh | w_lhu | w_sh;
  assign w_byte  = w_lb | w_lbu | w_sb;

  assign w_mis      = (w_half & addr_M[0]) | (w_word & (addr_M[1:0] != 2'b00));
  assign w_memop_ok = valid_M & (w_load | w_store) & ~w_mis;

  assign exc_adel = valid_M & w_load  & w_mis;
  assign exc_ades = valid_M & w_store & w_mis;

  // ---------------- byte enables / store data ----------------
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  always_comb begin
    w_be = '0;
    w_wd = wdata_M;
    if (w_word) begin
      w_be = 4'b1111;
    end else if (w_half) begin
      w_be = addr_M[1] ? 4'b1100 : 4'b0011;
      w_wd = {2{wdata_M[15:0]}};
    end else if (w_byte) begin
      w_be = 4'b0001 << addr_M[1:0];
      w_wd = {4{wdata_M[7:0]}};
    end
  end

  // ---------------- load extension ----------------
  // r_lsz: 00 byte, 01 half, 10 word; lane chosen by the latched addr[1:0]
  logic [1:0]  r_lo, r_lsz;
  logic        r_lsgn;
  logic [7:0]  w_bsel;
  logic [15:0] w_hsel;
  logic [31:0] w_ext;

  always_comb begin
    w_bsel = mem_rdata[7:0];
    case (r_lo)
      2'd0: w_bsel = mem_rdata[7:0];
      2'd1: w_bsel = mem_rdata[15:8];
      2'd2: w_bsel = mem_rdata[23:16];
      default: w_bsel = mem_rdata[31:24];
    endcase
    w_hsel = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_lsz)
      2'b00:   w_ext = {{24{r_lsgn & w_bsel[7]}}, w_bsel};
      2'b01:   w_ext = {{16{r_lsgn & w_hsel[15]}}, w_hsel};
      default: w_ext = mem_rdata;
    endcase
  end

  // ---------------- FSM ----------------
  logic [7:0] r_cnt;
  logic       r_tmo;
  logic       w_start, w_ack_done, w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_ack_done = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop_ok) begin
          w_next  = S_BUSY;
          w_start = 1'b1;
        end
      end
      S_BUSY: begin
        // ack wins over a timeout landing in the same cycle
        if (mem_ack) begin
          w_next     = S_DONE;
          w_ack_done = 1'b1;
        end else if (r_cnt == TMO_M1) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign stall_M  = ((r_state == S_IDLE) & w_memop_ok) | (r_state == S_BUSY);
  assign RegWrite = valid_M & (w_addu | w_subu | w_ori | w_lui | w_jal | w_load)
                  & ~w_mis & ~((r_state == S_DONE) & r_tmo);
  assign Mem2Reg  = w_jal ? 2'b10 : (w_load ? 2'b01 : 2'b00);

  // ---------------- registered datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      bus_err   <= 1'b0;
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_lo      <= '0;
      r_lsz     <= '0;
      r_lsgn    <= 1'b0;
    end else begin
      bus_err <= w_tmo;
      if (w_start) begin
        mem_req   <= 1'b1;
        mem_we    <= w_store;
        mem_addr  <= {addr_M[ADDR_W-1:2], 2'b00};
        mem_be    <= w_be;
        mem_wdata <= w_wd;
        r_cnt     <= '0;
        r_lo      <= addr_M[1:0];
        r_lsz     <= w_byte ? 2'b00 : (w_half ? 2'b01 : 2'b10);
        r_lsgn    <= w_lb | w_lh;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_ack_done | w_tmo) mem_req <= 1'b0;
      if (w_ack_done & ~mem_we) load_data <= w_ext;
      if (w_tmo) r_tmo <= 1'b1;
      else if (r_state == S_DONE) r_tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_m.sv
module tb_mem_ctrl_m;

  localparam logic [31:0] I_SW   = 32'hAC000000;
  localparam logic [31:0] I_LW   = 32'h8C000000;
  localparam logic [31:0] I_LB   = 32'h80000000;
  localparam logic [31:0] I_LBU  = 32'h90000000;
  localparam logic [31:0] I_LHU  = 32'h94000000;
  localparam logic [31:0] I_SH   = 32'hA4000000;
  localparam logic [31:0] I_JAL  = 32'h0C000000;
  localparam logic [31:0] I_ADDU = 32'h00000021;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_M;
  logic        valid_M, valid1;
  logic [31:0] addr_M, wdata_M;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        mem_req, mem_we, stall_M, RegWrite, exc_adel, exc_ades, bus_err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  logic [1:0]  Mem2Reg;

  logic        d1_req, d1_we, d1_stall, d1_rw, d1_adel, d1_ades, d1_berr;
  logic [31:0] d1_addr, d1_wdata, d1_ld;
  logic [3:0]  d1_be;
  logic [1:0]  d1_m2r;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl_m #(.ADDR_W(32), .SUBWORD(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr_M(instr_M), .valid_M(valid_M),
    .addr_M(addr_M), .wdata_M(wdata_M), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_M(stall_M),
    .RegWrite(RegWrite), .Mem2Reg(Mem2Reg), .load_data(load_data),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  mem_ctrl_m #(.ADDR_W(32), .SUBWORD(0), .TIMEOUT(16)) dut_nosub (
    .clk(clk), .reset(reset), .instr_M(instr_M), .valid_M(valid1),
    .addr_M(addr_M), .wdata_M(wdata_M), .mem_req(d1_req), .mem_we(d1_we),
    .mem_addr(d1_addr), .mem_be(d1_be), .mem_wdata(d1_wdata),
    .mem_ack(1'b0), .mem_rdata(mem_rdata), .stall_M(d1_stall),
    .RegWrite(d1_rw), .Mem2Reg(d1_m2r), .load_data(d1_ld),
    .exc_adel(d1_adel), .exc_ades(d1_ades), .bus_err(d1_berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_M = '0; valid_M = 1'b0; valid1 = 1'b0;
    addr_M = '0; wdata_M = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick; tick;
    chk("rst_req",   {31'd0, mem_req},  32'd0);
    chk("rst_we",    {31'd0, mem_we},   32'd0);
    chk("rst_addr",  mem_addr,          32'd0);
    chk("rst_be",    {28'd0, mem_be},   32'd0);
    chk("rst_wdata", mem_wdata,         32'd0);
    chk("rst_ld",    load_data,         32'd0);
    chk("rst_berr",  {31'd0, bus_err},  32'd0);
    chk("rst_stall", {31'd0, stall_M},  32'd0);
    reset = 1'b0;
    tick;

    // addu: single-cycle, writes back from ALU
    instr_M = I_ADDU; valid_M = 1'b1; settle;
    chk("addu_rw",    {31'd0, RegWrite}, 32'd1);
    chk("addu_m2r",   {30'd0, Mem2Reg},  32'd0);
    chk("addu_stall", {31'd0, stall_M},  32'd0);
    tick;

    // sw 0x12345678 @0x100, ack in first BUSY cycle
    instr_M = I_SW; addr_M = 32'h100; wdata_M = 32'h12345678; settle;
    chk("sw_c0_stall", {31'd0, stall_M},  32'd1);
    chk("sw_c0_req",   {31'd0, mem_req},  32'd0);
    chk("sw_c0_rw",    {31'd0, RegWrite}, 32'd0);
    tick;
    chk("sw_c1_req",   {31'd0, mem_req},  32'd1);
    chk("sw_c1_we",    {31'd0, mem_we},   32'd1);
    chk("sw_c1_be",    {28'd0, mem_be},   32'hF);
    chk("sw_c1_addr",  mem_addr,          32'h100);
    chk("sw_c1_wdata", mem_wdata,         32'h12345678);
    chk("sw_c1_stall", {31'd0, stall_M},  32'd1);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; settle;
    chk("sw_c2_req",   {31'd0, mem_req},  32'd0);
    chk("sw_c2_stall", {31'd0, stall_M},  32'd0);
    chk("sw_c2_rw",    {31'd0, RegWrite}, 32'd0);
    tick;

    // lb @0x203, rdata 0x80AABBCC, ack in third BUSY cycle
    instr_M = I_LB; addr_M = 32'h203; settle;
    chk("lb_c0_stall", {31'd0, stall_M},  32'd1);
    chk("lb_c0_rw",    {31'd0, RegWrite}, 32'd1);
    chk("lb_c0_m2r",   {30'd0, Mem2Reg},  32'd1);
    tick;
    chk("lb_b1_req",  {31'd0, mem_req}, 32'd1);
    chk("lb_b1_we",   {31'd0, mem_we},  32'd0);
    chk("lb_b1_be",   {28'd0, mem_be},  32'h8);
    chk("lb_b1_addr", mem_addr,         32'h200);
    tick;
    chk("lb_b2_req",   {31'd0, mem_req}, 32'd1);
    chk("lb_b2_stall", {31'd0, stall_M}, 32'd1);
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h80AABBCC;
    tick;
    mem_ack = 1'b0; mem_rdata = '0; settle;
    chk("lb_done_ld",    load_data,         32'hFFFFFF80);
    chk("lb_done_stall", {31'd0, stall_M},  32'd0);
    chk("lb_done_rw",    {31'd0, RegWrite}, 32'd1);
    chk("lb_done_m2r",   {30'd0, Mem2Reg},  32'd1);
    chk("lb_done_req",   {31'd0, mem_req},  32'd0);
    chk("lb_done_berr",  {31'd0, bus_err},  32'd0);
    tick;

    // sh 0xBEEF @0x12
    instr_M = I_SH; addr_M = 32'h12; wdata_M = 32'h0000BEEF; settle;
    chk("sh_c0_stall", {31'd0, stall_M}, 32'd1);
    tick;
    chk("sh_be",    {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata,       32'hBEEFBEEF);
    chk("sh_addr",  mem_addr,        32'h10);
    chk("sh_we",    {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; settle;
    chk("sh_done_stall", {31'd0, stall_M}, 32'd0);
    tick;

    // lhu @0x12, rdata 0xBEEF0000
    instr_M = I_LHU; settle;
    tick;
    chk("lhu_be", {28'd0, mem_be}, 32'hC);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF0000;
    tick;
    mem_ack = 1'b0; mem_rdata = '0; settle;
    chk("lhu_ld", load_data, 32'h0000BEEF);
    tick;

    // misaligned lw @0x102
    instr_M = I_LW; addr_M = 32'h102; settle;
    chk("lw_mis_adel",  {31'd0, exc_adel}, 32'd1);
    chk("lw_mis_ades",  {31'd0, exc_ades}, 32'd0);
    chk("lw_mis_stall", {31'd0, stall_M},  32'd0);
    chk("lw_mis_rw",    {31'd0, RegWrite}, 32'd0);
    tick;
    chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
    // misaligned sw @0x102
    instr_M = I_SW; settle;
    chk("sw_mis_ades",  {31'd0, exc_ades}, 32'd1);
    chk("sw_mis_adel",  {31'd0, exc_adel}, 32'd0);
    chk("sw_mis_stall", {31'd0, stall_M},  32'd0);
    tick;
    chk("sw_mis_req", {31'd0, mem_req}, 32'd0);

    // SUBWORD=0 instance: lb is not a memory op
    valid_M = 1'b0; valid1 = 1'b1; instr_M = I_LB; addr_M = 32'h203; settle;
    chk("nosub_lb_rw",    {31'd0, d1_rw},    32'd0);
    chk("nosub_lb_m2r",   {30'd0, d1_m2r},   32'd0);
    chk("nosub_lb_stall", {31'd0, d1_stall}, 32'd0);
    tick;
    chk("nosub_lb_req", {31'd0, d1_req}, 32'd0);
    instr_M = I_ADDU; settle;
    chk("nosub_addu_rw", {31'd0, d1_rw}, 32'd1);
    valid1 = 1'b0;
    tick;

    // timeout: lbu @0x5, no ack, TIMEOUT = 4
    valid_M = 1'b1; instr_M = I_LBU; addr_M = 32'h5; settle;
    chk("to_c0_stall", {31'd0, stall_M}, 32'd1);
    tick;
    chk("to_be", {28'd0, mem_be}, 32'h2);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_b%0d_req", i),  {31'd0, mem_req}, 32'd1);
      chk($sformatf("to_b%0d_berr", i), {31'd0, bus_err}, 32'd0);
      tick;
    end
    chk("to_done_req",   {31'd0, mem_req},  32'd0);
    chk("to_done_berr",  {31'd0, bus_err},  32'd1);
    chk("to_done_rw",    {31'd0, RegWrite}, 32'd0);
    chk("to_done_stall", {31'd0, stall_M},  32'd0);
    chk("to_done_ld",    load_data,         32'h0000BEEF);
    tick;

    // jal right after the timeout
    instr_M = I_JAL; addr_M = '0; settle;
    chk("jal_berr",  {31'd0, bus_err},  32'd0);
    chk("jal_m2r",   {30'd0, Mem2Reg},  32'd2);
    chk("jal_rw",    {31'd0, RegWrite}, 32'd1);
    chk("jal_stall", {31'd0, stall_M},  32'd0);
    tick;

    // reset pulsed during the second BUSY cycle of a sw
    instr_M = I_SW; addr_M = 32'h40; wdata_M = 32'hCAFEF00D; settle;
    tick;
    chk("rs_b1_req", {31'd0, mem_req}, 32'd1);
    tick;
    reset = 1'b1; valid_M = 1'b0; settle;
    chk("rs_req",   {31'd0, mem_req},  32'd0);
    chk("rs_we",    {31'd0, mem_we},   32'd0);
    chk("rs_addr",  mem_addr,          32'd0);
    chk("rs_be",    {28'd0, mem_be},   32'd0);
    chk("rs_wdata", mem_wdata,         32'd0);
    chk("rs_ld",    load_data,         32'd0);
    chk("rs_berr",  {31'd0, bus_err},  32'd0);
    chk("rs_stall", {31'd0, stall_M},  32'd0);
    tick;
    reset = 1'b0;
    tick;

    // sw after reset completes normally
    valid_M = 1'b1; instr_M = I_SW; addr_M = 32'h44; wdata_M = 32'h0BADBEEF; settle;
    chk("ps_c0_stall", {31'd0, stall_M}, 32'd1);
    tick;
    chk("ps_req",   {31'd0, mem_req}, 32'd1);
    chk("ps_addr",  mem_addr,         32'h44);
    chk("ps_be",    {28'd0, mem_be},  32'hF);
    chk("ps_wdata", mem_wdata,        32'h0BADBEEF);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; settle;
    chk("ps_done_req",   {31'd0, mem_req}, 32'd0);
    chk("ps_done_stall", {31'd0, stall_M}, 32'd0);
    chk("ps_done_berr",  {31'd0, bus_err}, 32'd0);
    valid_M = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
